// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external SRAM bus between the instruction-fetch
// port (read-only) and the data port (read/write with byte enables).
// Round-robin grant, registered req/ack handshake toward the bus, one-cycle
// DONE state per transfer that releases the requester's stall, and a per-cycle
// timeout that aborts a bus cycle whose ack never arrives.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction-fetch port
  input  logic        if_read,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  output logic        if_err,
  // data port
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_byte_en,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        dm_err,
  // external bus
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_BUS  = 3'd1,
    DM_BUS  = 3'd2,
    IF_DONE = 3'd3,
    DM_DONE = 3'd4
  } state_t;

  // Last counter value before the cycle is given up on.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             last_dm, last_dm_nx;   // 1 = data port won the last grant

  logic             req_nx, we_nx;
  logic [31:0]      addr_nx, wdata_nx;
  logic [3:0]       be_nx;
  logic [31:0]      if_rdata_nx, dm_rdata_nx;
  logic             if_err_nx, dm_err_nx;

  logic             dm_req;
  logic             grant_dm;
  logic             tmo;

  // Address bits [1:0] never reach the bus; the whole word is addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

  assign dm_req = dm_read | dm_write;

  // Round-robin: with both ports asking, the one that did not win last time goes.
  assign grant_dm = dm_req & (~if_read | ~last_dm);

  assign tmo = (cnt == CNT_LAST);

  // Stalls are purely combinational so the requester sees exactly one
  // stall-free cycle, the DONE cycle of its own transfer.
  assign if_stall = if_read & (state != IF_DONE);
  assign dm_stall = dm_req  & (state != DM_DONE);

  // Next-state and next-output logic; every register holds unless told otherwise.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    last_dm_nx  = last_dm;
    req_nx      = bus_req;
    we_nx       = bus_we;
    addr_nx     = bus_addr;
    be_nx       = bus_byte_en;
    wdata_nx    = bus_wdata;
    if_rdata_nx = if_rdata;
    dm_rdata_nx = dm_rdata;
    if_err_nx   = if_err;
    dm_err_nx   = dm_err;

    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_nx   = DM_BUS;
          req_nx     = 1'b1;
          we_nx      = dm_write;
          addr_nx    = {dm_addr[31:2], 2'b00};
          be_nx      = dm_write ? dm_byte_en : 4'b1111;
          wdata_nx   = dm_write ? dm_wdata : 32'h0;
          last_dm_nx = 1'b1;
          cnt_nx     = '0;
        end else if (if_read) begin
          state_nx   = IF_BUS;
          req_nx     = 1'b1;
          we_nx      = 1'b0;
          addr_nx    = {if_addr[31:2], 2'b00};
          be_nx      = 4'b1111;
          wdata_nx   = 32'h0;
          last_dm_nx = 1'b0;
          cnt_nx     = '0;
        end
      end

      IF_BUS: begin
        cnt_nx = cnt + 1'b1;
        // ack beats the timeout when both land in the same cycle
        if (bus_ack) begin
          req_nx      = 1'b0;
          if_rdata_nx = bus_rdata;
          if_err_nx   = 1'b0;
          state_nx    = IF_DONE;
        end else if (tmo) begin
          req_nx      = 1'b0;
          if_rdata_nx = 32'h0;
          if_err_nx   = 1'b1;
          state_nx    = IF_DONE;
        end
      end

      DM_BUS: begin
        cnt_nx = cnt + 1'b1;
        if (bus_ack) begin
          req_nx = 1'b0;
          // writes leave the read-data register untouched
          if (!bus_we) dm_rdata_nx = bus_rdata;
          dm_err_nx = 1'b0;
          state_nx  = DM_DONE;
        end else if (tmo) begin
          req_nx      = 1'b0;
          dm_rdata_nx = 32'h0;
          dm_err_nx   = 1'b1;
          state_nx    = DM_DONE;
        end
      end

      IF_DONE: begin
        if_err_nx = 1'b0;
        state_nx  = IDLE;
      end

      DM_DONE: begin
        dm_err_nx = 1'b0;
        state_nx  = IDLE;
      end

      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops bus_req immediately, mid-cycle or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last_dm     <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'h0;
      bus_byte_en <= 4'h0;
      bus_wdata   <= 32'h0;
      if_rdata    <= 32'h0;
      dm_rdata    <= 32'h0;
      if_err      <= 1'b0;
      dm_err      <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      last_dm     <= last_dm_nx;
      bus_req     <= req_nx;
      bus_we      <= we_nx;
      bus_addr    <= addr_nx;
      bus_byte_en <= be_nx;
      bus_wdata   <= wdata_nx;
      if_rdata    <= if_rdata_nx;
      dm_rdata    <= dm_rdata_nx;
      if_err      <= if_err_nx;
      dm_err      <= dm_err_nx;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed plus randomized transfers against a
// transaction-level reference model (grant order, bus fields, result).
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_read = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_stall, if_err;
  logic        dm_read = 1'b0, dm_write = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [3:0]  dm_byte_en = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_stall, dm_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit          last_m;      // 1 = data port granted last
  logic [31:0] if_rd_m, dm_rd_m;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_read(if_read), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_stall(if_stall), .if_err(if_err),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_byte_en(dm_byte_en), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_stall(dm_stall), .dm_err(dm_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_byte_en(bus_byte_en), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Round-robin rule: lone requester wins; with both, the one not served last.
  function automatic bit pick_dm(input bit ifr, input bit dmq, input bit last);
    if (ifr && dmq) return !last;
    return dmq;
  endfunction

  task automatic set_req(input bit ifr, input logic [31:0] ia, input bit dr, input bit dw,
                         input logic [31:0] da, input logic [3:0] be, input logic [31:0] wd);
    if_read = ifr; if_addr = ia;
    dm_read = dr; dm_write = dw; dm_addr = da; dm_byte_en = be; dm_wdata = wd;
  endtask

  // Entered in an IDLE cycle (posedge+2) with requests driven. dly < TIMEOUT
  // acks on bus cycle index dly; dly >= TIMEOUT lets the cycle time out.
  // Returns in the IDLE cycle after DONE, at posedge+2.
  task automatic xfer(input int dly, input logic [31:0] rd);
    bit dm, ewe, tmo;
    logic [31:0] ea, ew;
    logic [3:0] eb;
    int nwait;
    dm = pick_dm(if_read, dm_read | dm_write, last_m);
    last_m = dm;
    if (dm) begin
      ea = dm_addr & 32'hFFFF_FFFC; ewe = dm_write;
      eb = dm_write ? dm_byte_en : 4'b1111; ew = dm_write ? dm_wdata : 32'h0;
    end else begin
      ea = if_addr & 32'hFFFF_FFFC; ewe = 1'b0; eb = 4'b1111; ew = 32'h0;
    end
    tmo = (dly >= TIMEOUT);
    nwait = tmo ? TIMEOUT : dly;

    @(posedge clk); #2;
    chk("bus_addr", bus_addr, ea);
    chk("bus_we", 32'(bus_we), 32'(ewe));
    chk("bus_byte_en", 32'(bus_byte_en), 32'(eb));
    chk("bus_wdata", bus_wdata, ew);
    chk("grant_stall", 32'(dm ? dm_stall : if_stall), 32'd1);
    for (int i = 0; i < nwait; i++) begin
      chk("bus_req_hold", 32'(bus_req), 32'd1);
      @(posedge clk); #2;
    end
    if (!tmo) begin
      chk("bus_req_ack", 32'(bus_req), 32'd1);
      bus_ack = 1'b1; bus_rdata = rd;
      @(posedge clk); #2;
      bus_ack = 1'b0; bus_rdata = $urandom;
    end

    // DONE cycle
    chk("done_req", 32'(bus_req), 32'd0);
    if (dm) begin
      if (tmo) dm_rd_m = 32'h0;
      else if (!ewe) dm_rd_m = rd;
      chk("dm_stall_done", 32'(dm_stall), 32'd0);
      chk("dm_err_done", 32'(dm_err), 32'(tmo));
      chk("dm_rdata", dm_rdata, dm_rd_m);
      chk("if_stall_wait", 32'(if_stall), 32'(if_read));
      chk("if_rdata_keep", if_rdata, if_rd_m);
    end else begin
      if (tmo) if_rd_m = 32'h0;
      else if_rd_m = rd;
      chk("if_stall_done", 32'(if_stall), 32'd0);
      chk("if_err_done", 32'(if_err), 32'(tmo));
      chk("if_rdata", if_rdata, if_rd_m);
      chk("dm_stall_wait", 32'(dm_stall), 32'(dm_read | dm_write));
      chk("dm_rdata_keep", dm_rdata, dm_rd_m);
    end

    // IDLE cycle after DONE: error cleared, stall back while still requested
    @(posedge clk); #2;
    chk("idle_req", 32'(bus_req), 32'd0);
    chk("err_clear", 32'(dm ? dm_err : if_err), 32'd0);
    chk("stall_again", 32'(dm ? dm_stall : if_stall), 32'd1);
  endtask

  initial begin
    bit ifr, dr, dw;
    int op;

    last_m = 1'b0; if_rd_m = '0; dm_rd_m = '0;

    // reset values
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", 32'(bus_byte_en), 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    chk("rst_err", 32'({if_err, dm_err}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;

    // both reads held from reset: DM, IF, DM
    set_req(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0203, 4'h0, 32'h0);
    xfer(0, 32'h1111_1111);
    xfer(2, 32'h2222_2222);
    xfer(1, 32'h3333_3333);
    set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // single fetch, ack on the last cycle before timeout
    set_req(1'b1, 32'h0000_1006, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    xfer(3, 32'hDEAD_BEEF);
    set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // byte write, rdata untouched
    set_req(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0020, 4'b0100, 32'h5A5A_5A5A);
    xfer(1, 32'hFFFF_FFFF);

    // data read timeout
    set_req(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0);
    xfer(TIMEOUT, 32'h0);
    set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      ifr = 1'($urandom_range(0, 1));
      op  = $urandom_range(0, 2);
      dr  = (op == 1); dw = (op == 2);
      set_req(ifr, $urandom, dr, dw, $urandom, 4'($urandom), $urandom);
      if (!ifr && !dr && !dw) begin
        bus_ack = 1'b1; bus_rdata = $urandom;
        @(posedge clk); #2;
        bus_ack = 1'b0;
        chk("spur_req", 32'(bus_req), 32'd0);
        chk("spur_rdata", dm_rdata, dm_rd_m);
      end else begin
        xfer($urandom_range(0, TIMEOUT + 1), $urandom);
      end
    end
    set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // asynchronous reset in the middle of a data bus cycle
    set_req(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0F0C, 4'h0, 32'h0);
    @(posedge clk); #2;
    chk("pre_rst_req", 32'(bus_req), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus_req), 32'd0);
    chk("arst_addr", bus_addr, 32'd0);
    chk("arst_we_be", 32'({bus_we, bus_byte_en}), 32'd0);
    chk("arst_wdata", bus_wdata, 32'd0);
    chk("arst_rdata", if_rdata | dm_rdata, 32'd0);
    chk("arst_err", 32'({if_err, dm_err}), 32'd0);
    set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #2;
    bus_ack = 1'b0;
    chk("post_rst_req", 32'(bus_req), 32'd0);
    chk("post_rst_rdata", dm_rdata | if_rdata, 32'd0);
    chk("post_rst_stall", 32'({if_stall, dm_stall}), 32'd0);
    last_m = 1'b0; if_rd_m = '0; dm_rd_m = '0;

    // grant history cleared by reset: DM wins first again
    set_req(1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h0000_0600, 4'h0, 32'h0);
    xfer(0, 32'hCAFE_0001);
    xfer(0, 32'hCAFE_0002);
    set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
